// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for one shared tristate bus. It produces registered
// one-hot-or-zero driver enables, limits how long one owner may hold the bus,
// and forces an idle gap after each release so that two drivers never overlap.
module tristate_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         en,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] en_q, en_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       turn_cnt_q, turn_cnt_d;

  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   next_ptr;

  // Round-robin search: first set req bit at or after rr_ptr, with wrap.
  // Offsets are scanned from highest to lowest so the nearest one wins.
  always_comb begin
    pick = rr_ptr_q;
    cand = '0;
    for (int unsigned off = N_REQ; off > 0; off--) begin
      cand = IDW'((32'(rr_ptr_q) + off - 1) % N_REQ);
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

  // Pointer moves past the releasing owner so it drops to lowest priority.
  always_comb begin
    if (grant_id_q == IDW'(N_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id_q + IDW'(1);
    end
  end

  // Next-state and registered output computation for IDLE/GRANT/TURN.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      IDLE: begin
        en_d = '0;
        if (|req) begin
          en_d[pick] = 1'b1;
          grant_id_d = pick;
          hold_cnt_d = 8'd1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!req[grant_id_q] || (hold_cnt_q == 8'(MAX_HOLD))) begin
          en_d       = '0;
          rr_ptr_d   = next_ptr;
          turn_cnt_d = 4'd1;
          state_d    = TURN;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      TURN: begin
        en_d = '0;
        if (turn_cnt_q == 4'(TURNAROUND)) begin
          state_d = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end
      default: begin
        en_d    = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = |en_d;
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      en_q       <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign en       = en_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter with N_REQ=4, MAX_HOLD=4,
// TURNAROUND=1, followed by a random-request phase checking bus invariants.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] en;
  logic [1:0] grant_id;
  logic       busy;

  int checks = 0;
  int errors = 0;

  tristate_bus_arbiter #(
    .N_REQ      (4),
    .MAX_HOLD   (4),
    .TURNAROUND (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .en       (en),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_en,
                            input logic [1:0] e_id, input logic e_busy);
    check({tag, ".en"}, 32'(en), 32'(e_en));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(e_id));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  logic [3:0] rr_seq [5];
  logic [1:0] rr_id  [5];
  logic [3:0] prev_en;
  int         run_len;
  int         zero_len;

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // 1. Reset with every requester active, then first grant goes to 0.
    rst_n = 1'b0;
    req   = 4'b1111;
    #12;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("first_grant", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    step();
    expect_out("release0", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("idle0", 4'b0000, 2'd0, 1'b0);

    // 2. Short request from requester 1.
    req = 4'b0010;
    step();
    expect_out("short_rise", 4'b0010, 2'd1, 1'b1);
    step();
    expect_out("short_hold", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    step();
    expect_out("short_fall", 4'b0000, 2'd1, 1'b0);
    step();
    expect_out("short_idle", 4'b0000, 2'd1, 1'b0);

    // 3. Round robin with all requesting, from a fresh pointer.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        expect_out($sformatf("rr_own%0d_c%0d", o, c), rr_seq[o], rr_id[o], 1'b1);
      end
      if (o < 4) begin
        for (int g = 0; g < 2; g++) begin
          step();
          expect_out($sformatf("rr_gap%0d_%0d", o, g), 4'b0000, rr_id[o], 1'b0);
        end
      end
    end

    // 4. Lone requester 2 times out repeatedly and is re-granted after the gap.
    req = 4'b0100;
    step();
    expect_out("lone_gap0a", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("lone_gap0b", 4'b0000, 2'd0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        expect_out($sformatf("lone_r%0d_c%0d", r, c), 4'b0100, 2'd2, 1'b1);
      end
      if (r < 2) begin
        for (int g = 0; g < 2; g++) begin
          step();
          expect_out($sformatf("lone_gap%0d_%0d", r + 1, g), 4'b0000, 2'd2, 1'b0);
        end
      end
    end

    // 5. Grant requester 3, then assert reset between edges.
    req = 4'b1000;
    step();
    expect_out("to3_turn", 4'b0000, 2'd2, 1'b0);
    step();
    expect_out("to3_idle", 4'b0000, 2'd2, 1'b0);
    step();
    expect_out("to3_grant", 4'b1000, 2'd3, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111;
    #1;
    rst_n = 1'b1;
    step();
    expect_out("post_reset", 4'b0001, 2'd0, 1'b1);

    // 6. Random requests with invariant checks every cycle.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    prev_en  = 4'b0000;
    run_len  = 0;
    zero_len = 99;
    for (int n = 0; n < 2000; n++) begin
      req = 4'($urandom_range(0, 15));
      step();
      check("rand_onehot0", 32'($onehot0(en)), 32'd1);
      check("rand_busy", 32'(busy), 32'(|en));
      if (en != 4'b0000) begin
        if (prev_en == 4'b0000) begin
          check("rand_gap", 32'(zero_len >= 2), 32'd1);
          run_len = 1;
        end else begin
          check("rand_switch", 32'(en), 32'(prev_en));
          run_len++;
        end
        check("rand_hold", 32'(run_len <= 4), 32'd1);
        zero_len = 0;
      end else begin
        zero_len++;
        run_len = 0;
      end
      prev_en = en;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
